aes_host_sequencer: RTL and testbench

- Host-side front end for the AES engine top.
- Accepts one 128-bit key/plaintext request on a valid/ready port and serialises it into the engine's byte-wide din/cmd interface.
- Collects the 16 ciphertext bytes returned on dout/data_ok and presents them as one 128-bit result on a valid/ready port.
- Sits directly upstream (drives din/cmd) and downstream (consumes dout/data_ok) of the engine.

---
 rtl/aes_host_sequencer_if.sv | 70 +++++++
 rtl/aes_host_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_aes_host_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_host_sequencer_if.sv
// Bundle of the three ports of aes_host_sequencer.
//
//   Request port (valid/ready): req_valid, req_ready, req_key, req_plain, req_reuse_key.
//     Keys and plaintexts are big-endian by byte: [127:120] is byte 0.
//   Engine port: eng_din/eng_cmd to the engine, eng_ready/eng_dout/eng_data_ok back.
//     eng_cmd: 00 idle, 01 key byte, 10 plaintext byte, 11 start.
//   Result port (valid/ready): ct_valid, ct_ready, ct_data (first returned byte in [127:120]).
//   Status: timeout_err (one-cycle abort pulse), busy (sequencer not idle).
//
// Modports:
//   master - the sequencer's view.
//   slave  - the view of everything around it (requester, engine, result consumer).
interface aes_host_sequencer_if;

  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_key;
  logic [127:0] req_plain;
  logic         req_reuse_key;

  logic [7:0]   eng_din;
  logic [1:0]   eng_cmd;
  logic         eng_ready;
  logic [7:0]   eng_dout;
  logic         eng_data_ok;

  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] ct_data;

  logic         timeout_err;
  logic         busy;

  modport master (
    input  req_valid,
    input  req_key,
    input  req_plain,
    input  req_reuse_key,
    input  eng_ready,
    input  eng_dout,
    input  eng_data_ok,
    input  ct_ready,
    output req_ready,
    output eng_din,
    output eng_cmd,
    output ct_valid,
    output ct_data,
    output timeout_err,
    output busy
  );

  modport slave (
    output req_valid,
    output req_key,
    output req_plain,
    output req_reuse_key,
    output eng_ready,
    output eng_dout,
    output eng_data_ok,
    output ct_ready,
    input  req_ready,
    input  eng_din,
    input  eng_cmd,
    input  ct_valid,
    input  ct_data,
    input  timeout_err,
    input  busy
  );

endinterface

// File: rtl/aes_host_sequencer.sv
// Host-side front end for the byte-wide AES engine.
//
// Accepts one 128-bit key/plaintext request, streams it to the engine as 16 key bytes
// (skipped when the previously loaded key is reused), 16 plaintext bytes and a start
// command, then gathers the 16 returned ciphertext bytes into one 128-bit result.
//
// Ports:
//   clk  - clock, rising edge.
//   rst_ - synchronous reset, active high.
//   bus  - aes_host_sequencer_if.master: request, engine, result and status signals.
//
// Parameters:
//   TIMEOUT_CYCLES - idle cycles tolerated while waiting for a ciphertext byte (either the
//                    first one after start, or between two bytes) before aborting.
module aes_host_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  rst_,
  aes_host_sequencer_if.master bus
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT_CYCLES);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StKey     = 3'd1;
  localparam logic [2:0] StPt      = 3'd2;
  localparam logic [2:0] StStart   = 3'd3;
  localparam logic [2:0] StWaitOut = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  localparam logic [1:0] CmdIdle  = 2'b00;
  localparam logic [1:0] CmdKey   = 2'b01;
  localparam logic [1:0] CmdPt    = 2'b10;
  localparam logic [1:0] CmdStart = 2'b11;

  logic [2:0]      state_q, state_d;
  logic [127:0]    key_q, key_d;
  logic [127:0]    plain_q, plain_d;
  logic [127:0]    ct_q, ct_d;
  logic [3:0]      byte_cnt_q, byte_cnt_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            key_loaded_q, key_loaded_d;
  logic            timeout_err_q, timeout_err_d;

  logic            req_ready;
  logic            req_fire;
  logic            eng_fire;
  logic            last_byte;
  logic [6:0]      byte_sel;
  logic [7:0]      key_byte;
  logic [7:0]      plain_byte;
  logic [1:0]      eng_cmd;
  logic [7:0]      eng_din;
  logic [TmoW-1:0] tmo_inc;

  assign req_ready = (state_q == StIdle);
  assign req_fire  = bus.req_valid & req_ready;
  assign last_byte = (byte_cnt_q == 4'd15);

  // Byte n sits at bit offset 8*(15-n); for a 4-bit n, 15-n is simply ~n.
  assign byte_sel   = {~byte_cnt_q, 3'b000};
  assign key_byte   = key_q[byte_sel +: 8];
  assign plain_byte = plain_q[byte_sel +: 8];

  assign tmo_inc = tmo_cnt_q + TmoW'(1);

  // Engine drive depends on state only, so it holds for as long as eng_ready stays low.
  always_comb begin
    eng_cmd = CmdIdle;
    eng_din = 8'h00;
    case (state_q)
      StKey: begin
        eng_cmd = CmdKey;
        eng_din = key_byte;
      end
      StPt: begin
        eng_cmd = CmdPt;
        eng_din = plain_byte;
      end
      StStart: begin
        eng_cmd = CmdStart;
      end
      default: ;
    endcase
  end

  assign eng_fire = (eng_cmd != CmdIdle) & bus.eng_ready;

  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    plain_d       = plain_q;
    ct_d          = ct_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    key_loaded_d  = key_loaded_q;
    timeout_err_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (req_fire) begin
          key_d      = bus.req_key;
          plain_d    = bus.req_plain;
          byte_cnt_d = 4'd0;
          // A reuse request is only honoured once a key has actually been loaded.
          state_d    = (bus.req_reuse_key & key_loaded_q) ? StPt : StKey;
        end
      end

      StKey: begin
        if (eng_fire) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (last_byte) begin
            key_loaded_d = 1'b1;
            byte_cnt_d   = 4'd0;
            state_d      = StPt;
          end
        end
      end

      StPt: begin
        if (eng_fire) begin
          byte_cnt_d = byte_cnt_q + 4'd1;
          if (last_byte) begin
            byte_cnt_d = 4'd0;
            state_d    = StStart;
          end
        end
      end

      StStart: begin
        if (eng_fire) begin
          byte_cnt_d = 4'd0;
          tmo_cnt_d  = '0;
          state_d    = StWaitOut;
        end
      end

      StWaitOut: begin
        if (bus.eng_data_ok) begin
          ct_d       = {ct_q[119:0], bus.eng_dout};
          byte_cnt_d = byte_cnt_q + 4'd1;
          tmo_cnt_d  = '0;
          if (last_byte) begin
            byte_cnt_d = 4'd0;
            state_d    = StDone;
          end
        end else if (tmo_inc >= TmoLimit) begin
          // Abort: the partial ct stays in ct_q but is never flagged valid.
          timeout_err_d = 1'b1;
          tmo_cnt_d     = '0;
          byte_cnt_d    = 4'd0;
          state_d       = StIdle;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end

      StDone: begin
        if (bus.ct_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q       <= StIdle;
      key_q         <= '0;
      plain_q       <= '0;
      ct_q          <= '0;
      byte_cnt_q    <= 4'd0;
      tmo_cnt_q     <= '0;
      key_loaded_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      plain_q       <= plain_d;
      ct_q          <= ct_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      key_loaded_q  <= key_loaded_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.eng_cmd     = eng_cmd;
  assign bus.eng_din     = eng_din;
  assign bus.ct_valid    = (state_q == StDone);
  assign bus.ct_data     = ct_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_aes_host_sequencer.sv
// Directed bench for aes_host_sequencer. A stub engine records every key/plaintext/start
// transfer and answers each start with a programmed 16-byte response (with gaps between
// bytes), so the expected ciphertext is simply the programmed response.
module tb_aes_host_sequencer;

  localparam int unsigned TmoCycles = 8;

  localparam logic [127:0] KeyFips   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PlainFips = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtFips    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RespB     = 128'h0a1b2c3d4e5f60718293a4b5c6d7e8f9;
  localparam logic [127:0] RespC     = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

  logic clk = 1'b0;
  logic rst_ = 1'b1;
  always #5 clk = ~clk;

  aes_host_sequencer_if bus ();

  aes_host_sequencer #(
    .TIMEOUT_CYCLES(TmoCycles)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub engine state and transfer log.
  int           key_n, pt_n, start_n, out_left, out_idx, gap, n_out;
  int           last_ok_cyc, start_cyc, te_cnt, te_edge, hold_err, seq_err;
  logic [127:0] key_rx, pt_rx, resp;
  bit           rnd_ready, spurious, ctv_seen;
  int           hs_cyc;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Edges are labelled by the value of cyc seen at the preceding negedge.
  task automatic eng_loop();
    logic [1:0] prev_cmd;
    logic [7:0] prev_din;
    logic       prev_ready;
    prev_cmd   = 2'b00;
    prev_din   = 8'h00;
    prev_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_cmd != 2'b00 && !prev_ready &&
          (bus.eng_cmd != prev_cmd || bus.eng_din != prev_din)) hold_err++;
      if (bus.timeout_err) begin
        if (te_cnt == 0) te_edge = cyc - 1;
        te_cnt++;
      end
      if (bus.ct_valid) ctv_seen = 1'b1;

      bus.eng_ready   = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.eng_data_ok = 1'b0;
      bus.eng_dout    = 8'h5a;
      if (out_left > 0) begin
        if (gap > 0) begin
          gap--;
        end else begin
          bus.eng_data_ok = 1'b1;
          bus.eng_dout    = 8'(resp >> (8 * (15 - out_idx)));
          out_idx++;
          out_left--;
          if (out_left == 0) last_ok_cyc = cyc;
          gap = (out_idx % 4 == 0) ? 2 : 0;
        end
      end else if (spurious && (bus.eng_cmd == 2'b01 || bus.eng_cmd == 2'b10)) begin
        bus.eng_data_ok = 1'b1;
        bus.eng_dout    = 8'hee;
      end

      if (bus.eng_cmd != 2'b00 && bus.eng_ready) begin
        case (bus.eng_cmd)
          2'b01: begin
            if (pt_n != 0 || start_n != 0) seq_err++;
            key_rx = {key_rx[119:0], bus.eng_din};
            key_n++;
          end
          2'b10: begin
            if (start_n != 0) seq_err++;
            pt_rx = {pt_rx[119:0], bus.eng_din};
            pt_n++;
          end
          default: begin
            if (bus.eng_din != 8'h00) seq_err++;
            start_n++;
            start_cyc = cyc;
            out_left  = n_out;
            out_idx   = 0;
            gap       = 3;
          end
        endcase
      end
      prev_cmd   = bus.eng_cmd;
      prev_din   = bus.eng_din;
      prev_ready = bus.eng_ready;
    end
  endtask

  task automatic clear_eng(input logic [127:0] r, input int nout, input bit rnd, input bit spur);
    @(posedge clk);
    #1;
    key_n = 0; pt_n = 0; start_n = 0; out_left = 0; out_idx = 0; gap = 0;
    last_ok_cyc = -100; start_cyc = -100; te_cnt = 0; te_edge = -100;
    hold_err = 0; seq_err = 0; ctv_seen = 1'b0;
    key_rx = '0; pt_rx = '0;
    resp = r; n_out = nout; rnd_ready = rnd; spurious = spur;
  endtask

  task automatic send_req(input logic [127:0] k, input logic [127:0] p, input logic reuse);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_key       = k;
    bus.req_plain     = p;
    bus.req_reuse_key = reuse;
    bus.req_valid     = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_wait", bus.req_ready, 1'b1);
    hs_cyc = cyc;
    @(negedge clk);
    bus.req_valid     = 1'b0;
    bus.req_reuse_key = 1'b0;
  endtask

  task automatic do_txn(input string tag, input logic [127:0] k, input logic [127:0] p,
                        input logic reuse, input logic [127:0] r, input int exp_keys,
                        input int exp_lat, input bit rnd, input bit spur);
    int n;
    int ct_first;
    clear_eng(r, 16, rnd, spur);
    send_req(k, p, reuse);
    n = 0;
    while (bus.ct_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    ct_first = cyc;
    check_eq({tag, "_ct_valid"}, bus.ct_valid, 1'b1);
    check_eq({tag, "_ct_data"}, bus.ct_data, r);
    check_eq({tag, "_ct_rise"}, ct_first - last_ok_cyc, 1);
    check_eq({tag, "_key_n"}, key_n, exp_keys);
    if (exp_keys == 16) check_eq({tag, "_key_bytes"}, key_rx, k);
    check_eq({tag, "_pt_n"}, pt_n, 16);
    check_eq({tag, "_pt_bytes"}, pt_rx, p);
    check_eq({tag, "_start_n"}, start_n, 1);
    check_eq({tag, "_order"}, seq_err, 0);
    check_eq({tag, "_hold"}, hold_err, 0);
    if (exp_lat >= 0) check_eq({tag, "_latency"}, start_cyc - hs_cyc, exp_lat);
    check_eq({tag, "_busy_done"}, bus.busy, 1'b1);
    repeat (3) @(negedge clk);
    check_eq({tag, "_ct_valid_held"}, bus.ct_valid, 1'b1);
    check_eq({tag, "_ct_data_held"}, bus.ct_data, r);
    bus.ct_ready = 1'b1;
    @(negedge clk);
    bus.ct_ready = 1'b0;
    check_eq({tag, "_ct_valid_drop"}, bus.ct_valid, 1'b0);
    check_eq({tag, "_req_ready_after"}, bus.req_ready, 1'b1);
    check_eq({tag, "_busy_after"}, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  initial begin
    int n;
    bus.req_valid     = 1'b0;
    bus.req_key       = '0;
    bus.req_plain     = '0;
    bus.req_reuse_key = 1'b0;
    bus.ct_ready      = 1'b0;
    bus.eng_ready     = 1'b1;
    bus.eng_data_ok   = 1'b0;
    bus.eng_dout      = 8'h00;
    resp = '0; n_out = 16; rnd_ready = 1'b0; spurious = 1'b0;
    key_n = 0; pt_n = 0; start_n = 0; out_left = 0; out_idx = 0; gap = 0;
    last_ok_cyc = -100; start_cyc = -100; te_cnt = 0; te_edge = -100;
    hold_err = 0; seq_err = 0; ctv_seen = 1'b0; key_rx = '0; pt_rx = '0; hs_cyc = 0;
    fork
      eng_loop();
    join_none

    rst_ = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_ = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", bus.req_ready, 1'b1);
    check_eq("rst_eng_cmd", bus.eng_cmd, 2'b00);
    check_eq("rst_eng_din", bus.eng_din, 8'h00);
    check_eq("rst_ct_valid", bus.ct_valid, 1'b0);
    check_eq("rst_ct_data", bus.ct_data, '0);
    check_eq("rst_timeout_err", bus.timeout_err, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);

    // First request asks for reuse, but no key is loaded yet: full key load expected.
    do_txn("t1_fips", KeyFips, PlainFips, 1'b1, CtFips, 16, 33, 1'b0, 1'b0);
    do_txn("t2_reuse", KeyFips, '0, 1'b1, RespB, 0, 17, 1'b0, 1'b0);
    do_txn("t3_stall", KeyFips, PlainFips, 1'b0, CtFips, 16, -1, 1'b1, 1'b1);

    // Engine answers only 5 bytes, then goes silent.
    clear_eng(RespB, 5, 1'b0, 1'b0);
    send_req(KeyFips, PlainFips, 1'b1);
    n = 0;
    while (te_cnt == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check_eq("t4_tmo_pulse_width", te_cnt, 1);
    check_eq("t4_tmo_delay", te_edge - last_ok_cyc, TmoCycles);
    check_eq("t4_ct_valid_never", ctv_seen, 1'b0);
    check_eq("t4_req_ready", bus.req_ready, 1'b1);
    check_eq("t4_busy", bus.busy, 1'b0);
    check_eq("t4_key_n", key_n, 0);

    // Reset while the plaintext counter sits at 7.
    clear_eng(RespC, 16, 1'b0, 1'b0);
    send_req(KeyFips, PlainFips, 1'b1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (pt_n < 7 && n < 100);
    check_eq("t5_pt_cnt", pt_n, 7);
    check_eq("t5_key_n", key_n, 0);
    rst_ = 1'b1;
    @(posedge clk);
    #1 rst_ = 1'b0;
    check_eq("t5_busy", bus.busy, 1'b0);
    check_eq("t5_eng_cmd", bus.eng_cmd, 2'b00);
    check_eq("t5_eng_din", bus.eng_din, 8'h00);
    check_eq("t5_req_ready", bus.req_ready, 1'b1);
    check_eq("t5_ct_valid", bus.ct_valid, 1'b0);

    // Reset forgot the key, so a reuse request must reload it.
    do_txn("t6_after_rst", KeyFips, PlainFips, 1'b1, RespC, 16, 33, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
